// File: rtl/dice_pkg.sv
// Shared FSM state type, die-size constants and BCD / seven-segment helpers
// for the dice_bcd_roller block (up to four BCD digits).
package dice_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_ROLLING = 1'b1
    } state_t;

    localparam int MAX_DIGITS = 4;
    localparam int BCD_MAX_W  = 4 * MAX_DIGITS;

    localparam logic [BCD_MAX_W-1:0] SIDES_D4   = 16'h0004;
    localparam logic [BCD_MAX_W-1:0] SIDES_D6   = 16'h0006;
    localparam logic [BCD_MAX_W-1:0] SIDES_D8   = 16'h0008;
    localparam logic [BCD_MAX_W-1:0] SIDES_D10  = 16'h0010;
    localparam logic [BCD_MAX_W-1:0] SIDES_D12  = 16'h0012;
    localparam logic [BCD_MAX_W-1:0] SIDES_D20  = 16'h0020;
    localparam logic [BCD_MAX_W-1:0] SIDES_D100 = 16'h0100;

    // Segment order {g,f,e,d,c,b,a}, active-high; blank or non-decimal gives all-off.
    function automatic logic [6:0] seg7(input logic [3:0] digit, input logic blank);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        if (blank) seg = 7'h00;
        return seg;
    endfunction

    function automatic logic [BCD_MAX_W-1:0] bcd_dec(input logic [BCD_MAX_W-1:0] v,
                                                     input int digits);
        logic [BCD_MAX_W-1:0] res;
        logic                 borrow;
        res    = v;
        borrow = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (borrow && (i < digits)) begin
                if (v[4*i +: 4] == 4'd0) begin
                    res[4*i +: 4] = 4'd9;
                end else begin
                    res[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dice_bcd_roller_debouncer.sv
// Roll button conditioner: 2-flop synchroniser followed by a tick-sampled
// filter that only accepts a new level after two consecutive samples agree.
module roll_debouncer (
    input  logic clk,
    input  logic rst_n,
    input  logic i_roll,
    input  logic i_tick,
    output logic o_roll_db
);
    logic [1:0] r_sync;
    logic       r_samp;
    logic       r_db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
            r_samp <= 1'b0;
            r_db   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_roll};
            if (i_tick) begin
                r_samp <= r_sync[1];
                if (r_sync[1] == r_samp) r_db <= r_sync[1];
            end
        end
    end

    assign o_roll_db = r_db;

endmodule

// File: rtl/dice_bcd_roller.sv
// N-digit BCD dice roller: debounced roll, free-running BCD countdown, release-to-latch
// result, multiplexed 7-seg drive. Define DICE_ROLLER_ANIM_EN for the rolling animation.
module dice_bcd_roller
    import dice_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int PRESCALE_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    roll,
    input  logic [2:0]              sides_sel,
    input  logic [4*NUM_DIGITS-1:0] sides_custom,
    input  logic                    inv_seg,
    input  logic                    inv_dig,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_out,
    output logic [4*NUM_DIGITS-1:0] result,
    output logic                    result_valid
);
    localparam int                VW        = 4 * NUM_DIGITS;
    localparam int                SCAN_W    = (NUM_DIGITS > 2) ? 2 : 1;
    localparam logic [VW-1:0]     BCD_ONE   = VW'(1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NUM_DIGITS - 1);

    // Die sizes that do not fit the digit count clamp to all-9s.
    function automatic logic [VW-1:0] sat_sides(input logic [BCD_MAX_W-1:0] full);
        if ((full >> VW) != '0) return {NUM_DIGITS{4'd9}};
        return full[VW-1:0];
    endfunction

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    logic [PRESCALE_W-1:0] r_presc;
    logic                  w_tick;
    logic                  w_roll_db;
    logic                  r_db_q;
    logic                  w_rise;
    logic                  w_fall;
    state_t                r_state;
    logic [VW-1:0]         r_value;
    logic [VW-1:0]         r_sides_q;
    logic [VW-1:0]         r_result;
    logic                  r_result_valid;
    logic [2:0]            r_sel_q;
    logic                  r_sel_chg;
    logic [BCD_MAX_W-1:0]  w_sides_full;
    logic [VW-1:0]         w_sides;
    logic [VW-1:0]         w_dec;
    logic [SCAN_W-1:0]     r_scan;
    logic [3:0]            w_nib;
    logic                  w_blank;
    logic [6:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_dig;

    // Reset asserts asynchronously, releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_presc <= '0;
        else          r_presc <= r_presc + 1'b1;
    end
    assign w_tick = (r_presc == '0);

    roll_debouncer u_debouncer (
        .clk       (clk),
        .rst_n     (w_rst_n),
        .i_roll    (roll),
        .i_tick    (w_tick),
        .o_roll_db (w_roll_db)
    );

    always_comb begin
        w_sides_full = '0;
        case (sides_sel)
            3'd0:    w_sides_full = SIDES_D4;
            3'd1:    w_sides_full = SIDES_D6;
            3'd2:    w_sides_full = SIDES_D8;
            3'd3:    w_sides_full = SIDES_D10;
            3'd4:    w_sides_full = SIDES_D12;
            3'd5:    w_sides_full = SIDES_D20;
            3'd6:    w_sides_full = SIDES_D100;
            default: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    w_sides_full[4*i +: 4] = (sides_custom[4*i +: 4] > 4'd9) ? 4'd9
                                                                             : sides_custom[4*i +: 4];
                end
            end
        endcase
    end

    assign w_sides = sat_sides(w_sides_full);
    assign w_dec   = VW'(bcd_dec(BCD_MAX_W'(r_value), NUM_DIGITS));
    assign w_rise  = w_roll_db & ~r_db_q;
    assign w_fall  = ~w_roll_db & r_db_q;

    // Select changes are only honoured in IDLE so a return from ROLLING never reloads.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state        <= ST_IDLE;
            r_value        <= BCD_ONE;
            r_sides_q      <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_db_q         <= 1'b0;
            r_sel_q        <= 3'd0;
            r_sel_chg      <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_db_q         <= w_roll_db;
            r_sel_q        <= sides_sel;
            r_sel_chg      <= (sides_sel != r_sel_q) && (r_state == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state   <= ST_ROLLING;
                        r_sides_q <= w_sides;
                        r_value   <= w_sides;
                    end else if (r_sel_chg) begin
                        r_value <= w_sides;
                    end
                end
                default: begin
                    if (w_fall) begin
                        r_state        <= ST_IDLE;
                        r_result       <= r_value;
                        r_result_valid <= 1'b1;
                    end else if (r_sides_q == '0) begin
                        r_value <= '0;
                    end else if (r_value == BCD_ONE) begin
                        r_value <= r_sides_q;
                    end else begin
                        r_value <= w_dec;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)                r_scan <= '0;
        else if (r_scan == SCAN_LAST) r_scan <= '0;
        else                         r_scan <= r_scan + 1'b1;
    end

`ifdef DICE_ROLLER_ANIM_EN
    logic [2:0] r_anim;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)                   r_anim <= 3'd0;
        else if (r_state != ST_ROLLING) r_anim <= 3'd0;
        else if (w_tick)                r_anim <= (r_anim == 3'd5) ? 3'd0 : r_anim + 3'd1;
    end
`endif

    always_comb begin
        w_nib   = r_value[4*r_scan +: 4];
        w_blank = (r_scan != '0) && ((r_value >> (4*r_scan)) == '0);
        w_seg   = seg7(w_nib, w_blank);
        w_dig   = NUM_DIGITS'(1) << r_scan;
        if (r_state == ST_ROLLING) begin
`ifdef DICE_ROLLER_ANIM_EN
            w_seg = 7'd1 << r_anim;
`else
            w_seg = 7'd0;
            w_dig = '0;
`endif
        end
    end

    assign seg_out      = {1'b0, w_seg} ^ {8{inv_seg}};
    assign dig_out      = w_dig ^ {NUM_DIGITS{inv_dig}};
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule
